// File: rtl/stack_lifo.sv
// stack_lifo
//   LIFO stack for the UAZ 8-bit datapath. Holds return addresses and saved
//   register values. The most recently popped word is held in a register
//   that feeds the register-input multiplexer.
//
// Ports
//   i_Clk               system clock, rising edge
//   i_Reset             synchronous active-high reset
//   i_Push / i_Pop      operation requests for this cycle
//   i_Dato              word to push
//   o_Senal_a_stack     registered last popped word
//   o_Valido            one-cycle pulse when o_Senal_a_stack was just loaded
//   o_Cuenta            occupied entries, 0..DEPTH
//   o_Vacio / o_Lleno   empty / full, decoded from the count
//   o_Desbordamiento    sticky: push attempted while full
//   o_Subdesbordamiento sticky: pop attempted while empty
//
// DEPTH must be a power of two and at least 2. PTR_W is derived.
module stack_lifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Push,
  input  logic                  i_Pop,
  input  logic [DATA_WIDTH-1:0] i_Dato,
  output logic [DATA_WIDTH-1:0] o_Senal_a_stack,
  output logic                  o_Valido,
  output logic [PTR_W:0]        o_Cuenta,
  output logic                  o_Vacio,
  output logic                  o_Lleno,
  output logic                  o_Desbordamiento,
  output logic                  o_Subdesbordamiento
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  // Per-cycle action, resolved from the request pair and occupancy.
  localparam logic [2:0] OP_IDLE      = 3'd0;
  localparam logic [2:0] OP_PUSH      = 3'd1;
  localparam logic [2:0] OP_PUSH_FULL = 3'd2;
  localparam logic [2:0] OP_POP       = 3'd3;
  localparam logic [2:0] OP_POP_EMPTY = 3'd4;
  localparam logic [2:0] OP_REPLACE   = 3'd5;
  localparam logic [2:0] OP_PASS      = 3'd6;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]        cnt;
  logic [PTR_W-1:0]      wr_idx;
  logic [PTR_W-1:0]      top_idx;
  logic                  empty;
  logic                  full;
  logic [2:0]            op;

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_FULL);

  // When full, cnt's low bits are zero, so cnt-1 in PTR_W bits lands on
  // DEPTH-1 as required; wr_idx is never used while full.
  assign wr_idx  = cnt[PTR_W-1:0];
  assign top_idx = cnt[PTR_W-1:0] - 1'b1;

  always_comb begin
    op = OP_IDLE;
    case ({i_Push, i_Pop})
      2'b10:   op = full  ? OP_PUSH_FULL : OP_PUSH;
      2'b01:   op = empty ? OP_POP_EMPTY : OP_POP;
      2'b11:   op = empty ? OP_PASS      : OP_REPLACE;
      default: op = OP_IDLE;
    endcase
  end

  // Storage is deliberately not reset; reset only empties the stack by count.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      if (op == OP_PUSH)
        mem[wr_idx] <= i_Dato;
      else if (op == OP_REPLACE)
        mem[top_idx] <= i_Dato;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cnt                 <= '0;
      o_Senal_a_stack     <= '0;
      o_Valido            <= 1'b0;
      o_Desbordamiento    <= 1'b0;
      o_Subdesbordamiento <= 1'b0;
    end else begin
      o_Valido <= 1'b0;
      case (op)
        OP_PUSH: begin
          cnt <= cnt + 1'b1;
        end
        OP_PUSH_FULL: begin
          o_Desbordamiento <= 1'b1;
        end
        OP_POP: begin
          o_Senal_a_stack <= mem[top_idx];
          o_Valido        <= 1'b1;
          cnt             <= cnt - 1'b1;
        end
        OP_POP_EMPTY: begin
          o_Subdesbordamiento <= 1'b1;
        end
        OP_REPLACE: begin
          // Old top goes out while the new word overwrites it in place.
          o_Senal_a_stack <= mem[top_idx];
          o_Valido        <= 1'b1;
        end
        OP_PASS: begin
          o_Senal_a_stack <= i_Dato;
          o_Valido        <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_Cuenta = cnt;
  assign o_Vacio  = empty;
  assign o_Lleno  = full;

endmodule

// File: tb/tb_stack_lifo.sv
module tb_stack_lifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          push;
  logic          pop;
  logic [DW-1:0] dato;
  logic [DW-1:0] senal;
  logic          valido;
  logic [PW:0]   cuenta;
  logic          vacio;
  logic          lleno;
  logic          desb;
  logic          subd;

  stack_lifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_Clk              (clk),
    .i_Reset            (rst),
    .i_Push             (push),
    .i_Pop              (pop),
    .i_Dato             (dato),
    .o_Senal_a_stack    (senal),
    .o_Valido           (valido),
    .o_Cuenta           (cuenta),
    .o_Vacio            (vacio),
    .o_Lleno            (lleno),
    .o_Desbordamiento   (desb),
    .o_Subdesbordamiento(subd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: a queue whose back is the top of stack.
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_out;
  logic          m_valid;
  logic          m_ovf;
  logic          m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model(input logic p, input logic o, input logic [DW-1:0] d, input logic r);
    if (r) begin
      q.delete();
      m_out = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (p && o) begin
        m_valid = 1'b1;
        if (q.size() > 0) begin
          m_out = q[q.size()-1];
          q[q.size()-1] = d;
        end else begin
          m_out = d;
        end
      end else if (p) begin
        if (q.size() < DEPTH) q.push_back(d);
        else m_ovf = 1'b1;
      end else if (o) begin
        if (q.size() > 0) begin
          m_out = q.pop_back();
          m_valid = 1'b1;
        end else begin
          m_unf = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":data"},   32'(senal),  32'(m_out));
    chk({tag, ":valid"},  32'(valido), 32'(m_valid));
    chk({tag, ":count"},  32'(cuenta), 32'(q.size()));
    chk({tag, ":empty"},  32'(vacio),  32'(q.size() == 0));
    chk({tag, ":full"},   32'(lleno),  32'(q.size() == DEPTH));
    chk({tag, ":ovf"},    32'(desb),   32'(m_ovf));
    chk({tag, ":unf"},    32'(subd),   32'(m_unf));
  endtask

  task automatic step(input logic p, input logic o, input logic [DW-1:0] d,
                      input logic r, input string tag);
    push = p; pop = o; dato = d; rst = r;
    @(posedge clk);
    #1;
    model(p, o, d, r);
    check_all(tag);
  endtask

  initial begin
    push = 1'b0; pop = 1'b0; dato = '0; rst = 1'b1;

    // Basic push/pop order
    step(0, 0, 8'h00, 1, "rst");
    step(1, 0, 8'h11, 0, "push11");
    step(1, 0, 8'h22, 0, "push22");
    step(1, 0, 8'h33, 0, "push33");
    step(0, 1, 8'h00, 0, "pop1");
    chk("pop1_const", 32'(senal), 32'h33);
    step(0, 1, 8'h00, 0, "pop2");
    chk("pop2_const", 32'(senal), 32'h22);
    step(0, 1, 8'h00, 0, "pop3");
    chk("pop3_const", 32'(senal), 32'h11);
    step(0, 0, 8'h00, 0, "idle");

    // Fill, overflow, pop returns the last accepted word
    step(0, 0, 8'h00, 1, "rst2");
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'hA0 + 8'(i), 0, "fill");
    step(1, 0, 8'hFF, 0, "ovf_push");
    chk("ovf_flag", 32'(desb), 32'd1);
    step(0, 1, 8'h00, 0, "pop_after_ovf");
    chk("pop_after_ovf_const", 32'(senal), 32'hA7);
    // Replace-top while full raises no overflow beyond what is sticky
    step(1, 0, 8'hB0, 0, "refill");
    step(1, 1, 8'hB1, 0, "replace_full");

    // Underflow right after reset
    step(0, 0, 8'h00, 1, "rst3");
    step(0, 1, 8'h00, 0, "unf_pop");
    chk("unf_flag", 32'(subd), 32'd1);
    step(1, 0, 8'h44, 0, "push_after_unf");
    step(0, 1, 8'h00, 0, "pop_after_unf");

    // Replace-top
    step(0, 0, 8'h00, 1, "rst4");
    step(1, 0, 8'h5A, 0, "push5A");
    step(1, 1, 8'hC3, 0, "replace");
    chk("replace_const", 32'(senal), 32'h5A);
    step(0, 0, 8'h00, 0, "idle2");
    step(0, 1, 8'h00, 0, "pop_C3");
    chk("pop_C3_const", 32'(senal), 32'hC3);

    // Pass-through on empty
    step(0, 0, 8'h00, 1, "rst5");
    step(1, 1, 8'h7E, 0, "pass");
    chk("pass_const", 32'(senal), 32'h7E);

    // Reset together with pop mid-sequence
    for (int i = 0; i < 4; i++) step(1, 0, 8'h60 + 8'(i), 0, "push4");
    step(0, 1, 8'h00, 1, "rst_pop");
    chk("rst_pop_count", 32'(cuenta), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic p, o, r;
      logic [DW-1:0] d;
      p = ($urandom_range(0, 99) < 55);
      o = ($urandom_range(0, 99) < 45);
      r = ($urandom_range(0, 199) == 0);
      d = DW'($urandom);
      step(p, o, d, r, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
